// File: rtl/rob_param_pkg.sv
// Shared reorder-buffer configuration: default widths, branch-direction encoding
// and the retire operation chosen for the head entry each cycle.
package rob_param_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef enum logic {
        NOT_JUMP = 1'b0,
        JUMP     = 1'b1
    } jump_e;

    typedef enum logic [1:0] {
        RET_NONE,
        RET_COMMIT,
        RET_REDIRECT,
        RET_STORE
    } retire_op_e;

    function automatic logic is_mispredict(input logic pred, input logic taken);
        return pred != taken;
    endfunction

endpackage

// File: rtl/rob_param_ptr_ctr.sv
// Circular pointer for the reorder buffer: advances on inc, wraps DEPTH-1 -> 0,
// and snaps back to 0 on clr.
module rob_ptr_ctr #(
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rob_param.sv
// Parameterised reorder buffer: allocates in order, accepts out-of-order writebacks,
// retires one entry per cycle with a store handshake and mispredict redirect.
module rob_param
    import rob_param_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  REG_W  = DEF_REG_W,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_is_store,
    input  logic              alloc_pred_taken,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb0_taken,
    input  logic [ADDR_W-1:0] wb0_target,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              cmt_valid,
    output logic [REG_W-1:0]  cmt_rd,
    output logic [DATA_W-1:0] cmt_data,
    output logic [TAG_W-1:0]  cmt_tag,
    output logic              st_valid,
    output logic [TAG_W-1:0]  st_tag,
    input  logic              st_ack,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              flush_in,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  is_store_q;
    jump_e             pred_q   [DEPTH];
    jump_e             taken_q  [DEPTH];
    logic [REG_W-1:0]  rd_q     [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count_q;
    logic              redirect_q;
    logic [ADDR_W-1:0] redirect_pc_q;

    retire_op_e        retire_op;
    logic              active;
    logic              do_alloc;
    logic              do_retire;
    logic              clr_all;
    logic              wb0_hit;
    logic              wb1_hit;

    assign active = rdy && !flush_in;

    always_comb begin
        retire_op = RET_NONE;
        if (active && valid_q[head]) begin
            if (is_store_q[head]) begin
                retire_op = RET_STORE;
            end else if (done_q[head]) begin
                retire_op = is_mispredict(pred_q[head], taken_q[head]) ? RET_REDIRECT : RET_COMMIT;
            end
        end
    end

    assign cmt_valid = (retire_op == RET_COMMIT) || (retire_op == RET_REDIRECT);
    assign st_valid  = (retire_op == RET_STORE);
    assign do_retire = cmt_valid || (st_valid && st_ack);
    assign clr_all   = flush_in || (retire_op == RET_REDIRECT);

    // No bypass of a retiring entry: a full ROB refuses allocation even while the head leaves.
    assign alloc_ready = rst && active && !redirect_q && (count_q < FULL_CNT);
    assign do_alloc    = alloc_valid && alloc_ready;

    // wb0 wins a same-tag collision, so wb1 is dropped rather than merged.
    assign wb0_hit = active && wb0_valid && valid_q[wb0_tag];
    assign wb1_hit = active && wb1_valid && valid_q[wb1_tag] && !(wb0_valid && (wb0_tag == wb1_tag));

    assign alloc_tag      = tail;
    assign cmt_rd         = rd_q[head];
    assign cmt_data       = data_q[head];
    assign cmt_tag        = head;
    assign st_tag         = head;
    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign count          = count_q;

    rob_ptr_ctr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_retire),
        .clr (clr_all),
        .ptr (head)
    );

    rob_ptr_ctr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_alloc),
        .clr (clr_all),
        .ptr (tail)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb0_hit) done_q[wb0_tag] <= 1'b1;
            if (wb1_hit) done_q[wb1_tag] <= 1'b1;
            if (do_retire) valid_q[head] <= 1'b0;
            if (do_alloc) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
            end
            count_q <= count_q + (TAG_W + 1)'(do_alloc) - (TAG_W + 1)'(do_retire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= (retire_op == RET_REDIRECT);
            if (retire_op == RET_REDIRECT) redirect_pc_q <= target_q[head];
        end
    end

    // Payload is qualified by valid_q, so it needs no reset; taken starts equal to
    // the prediction so results arriving through wb1 never look mispredicted.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            is_store_q[tail] <= alloc_is_store;
            pred_q[tail]     <= jump_e'(alloc_pred_taken);
            taken_q[tail]    <= jump_e'(alloc_pred_taken);
            rd_q[tail]       <= alloc_rd;
        end
        if (wb0_hit) begin
            data_q[wb0_tag]   <= wb0_data;
            taken_q[wb0_tag]  <= jump_e'(wb0_taken);
            target_q[wb0_tag] <= wb0_target;
        end
        if (wb1_hit) data_q[wb1_tag] <= wb1_data;
    end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed vector table, hand-written corner
// sequences and a randomised run against a queue-based reference model.
module tb_rob_param;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy, alloc_valid, alloc_ready, alloc_is_store, alloc_pred_taken;
    logic [REG_W-1:0]  alloc_rd, cmt_rd;
    logic [TAG_W-1:0]  alloc_tag, wb0_tag, wb1_tag, cmt_tag, st_tag;
    logic              wb0_valid, wb0_taken, wb1_valid, cmt_valid, st_valid, st_ack;
    logic [DATA_W-1:0] wb0_data, wb1_data, cmt_data;
    logic [ADDR_W-1:0] wb0_target, redirect_pc;
    logic              redirect_valid, flush_in;
    logic [TAG_W:0]    count;

    always #5 clk = ~clk;

    rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_is_store(alloc_is_store), .alloc_pred_taken(alloc_pred_taken), .alloc_tag(alloc_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb0_taken(wb0_taken), .wb0_target(wb0_target),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_data(cmt_data), .cmt_tag(cmt_tag),
        .st_valid(st_valid), .st_tag(st_tag), .st_ack(st_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_in(flush_in), .count(count)
    );

    typedef struct {
        bit rdy; bit av; bit ast; bit apred; bit [REG_W-1:0] ard;
        bit w0v; bit [TAG_W-1:0] w0t; bit [DATA_W-1:0] w0d; bit w0k; bit [ADDR_W-1:0] w0pc;
        bit w1v; bit [TAG_W-1:0] w1t; bit [DATA_W-1:0] w1d;
        bit ack; bit fl;
    } stim_t;

    typedef struct {
        stim_t s; bit ar; bit [TAG_W-1:0] tag; bit cv; bit [TAG_W-1:0] ct; bit [DATA_W-1:0] cd; int cnt;
    } vec_t;

    typedef struct {
        int tag; bit st; bit pred; bit [REG_W-1:0] rd;
        bit done; bit taken; bit [DATA_W-1:0] data; bit [ADDR_W-1:0] target;
    } ent_t;

    // Reference model: the in-flight entries in program order, oldest first.
    ent_t              rob_q[$];
    int                next_tag;
    bit                m_redir;
    bit [ADDR_W-1:0]   m_rpc;

    stim_t cur;
    vec_t  tbl[12];
    int    checks = 0;
    int    errors = 0;

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t mk_alloc(int rd);
        stim_t s = idle();
        s.av  = 1'b1;
        s.ard = REG_W'(rd);
        return s;
    endfunction

    function automatic stim_t mk_wb0(int tag, int data);
        stim_t s = idle();
        s.w0v = 1'b1;
        s.w0t = TAG_W'(tag);
        s.w0d = DATA_W'(data);
        return s;
    endfunction

    function automatic stim_t mk_wb1(int tag, int data);
        stim_t s = idle();
        s.w1v = 1'b1;
        s.w1t = TAG_W'(tag);
        s.w1d = DATA_W'(data);
        return s;
    endfunction

    function automatic bit m_alloc_ready(stim_t s);
        return s.rdy && !s.fl && !m_redir && (rob_q.size() < DEPTH);
    endfunction

    function automatic bit m_cmt(stim_t s);
        return s.rdy && !s.fl && (rob_q.size() > 0) && !rob_q[0].st && rob_q[0].done;
    endfunction

    function automatic bit m_st(stim_t s);
        return s.rdy && !s.fl && (rob_q.size() > 0) && rob_q[0].st;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(stim_t s);
        rdy = s.rdy; alloc_valid = s.av; alloc_is_store = s.ast;
        alloc_pred_taken = s.apred; alloc_rd = s.ard;
        wb0_valid = s.w0v; wb0_tag = s.w0t; wb0_data = s.w0d; wb0_taken = s.w0k; wb0_target = s.w0pc;
        wb1_valid = s.w1v; wb1_tag = s.w1t; wb1_data = s.w1d;
        st_ack = s.ack; flush_in = s.fl;
    endtask

    task automatic model_reset();
        rob_q.delete();
        next_tag = 0;
        m_redir  = 1'b0;
        m_rpc    = '0;
    endtask

    // Retire decisions use the state seen before the edge; writebacks land at the same edge.
    task automatic model_update(stim_t s);
        bit   ar, cv, sv;
        ent_t h;
        ar = m_alloc_ready(s);
        cv = m_cmt(s);
        sv = m_st(s);
        m_redir = 1'b0;
        if (s.fl) begin
            rob_q.delete();
            next_tag = 0;
            return;
        end
        if (!s.rdy) return;
        if (cv) h = rob_q[0];
        for (int i = 0; i < rob_q.size(); i++) begin
            if (s.w0v && rob_q[i].tag == int'(s.w0t)) begin
                rob_q[i].done = 1'b1; rob_q[i].data = s.w0d;
                rob_q[i].taken = s.w0k; rob_q[i].target = s.w0pc;
            end else if (s.w1v && rob_q[i].tag == int'(s.w1t)) begin
                rob_q[i].done = 1'b1; rob_q[i].data = s.w1d;
            end
        end
        if (cv) begin
            void'(rob_q.pop_front());
            if (h.pred != h.taken) begin
                rob_q.delete();
                next_tag = 0;
                m_redir  = 1'b1;
                m_rpc    = h.target;
                return;
            end
        end else if (sv && s.ack) begin
            void'(rob_q.pop_front());
        end
        if (s.av && ar) begin
            rob_q.push_back('{next_tag, s.ast, s.apred, s.ard, 1'b0, s.apred, '0, '0});
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic applyStimulus(stim_t s);
        @(negedge clk);
        cur = s;
        drive(s);
        #1;
    endtask

    task automatic checkOutput();
        bit cv, sv;
        cv = m_cmt(cur);
        sv = m_st(cur);
        chk("alloc_ready", 64'(alloc_ready), 64'(m_alloc_ready(cur)));
        chk("alloc_tag", 64'(alloc_tag), 64'(next_tag));
        chk("cmt_valid", 64'(cmt_valid), 64'(cv));
        if (cv) begin
            chk("cmt_tag", 64'(cmt_tag), 64'(rob_q[0].tag));
            chk("cmt_rd", 64'(cmt_rd), 64'(rob_q[0].rd));
            chk("cmt_data", 64'(cmt_data), 64'(rob_q[0].data));
        end
        chk("st_valid", 64'(st_valid), 64'(sv));
        if (sv) chk("st_tag", 64'(st_tag), 64'(rob_q[0].tag));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
        if (m_redir) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        chk("count", 64'(count), 64'(rob_q.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(cur);
    endtask

    task automatic step(stim_t s);
        applyStimulus(s);
        checkOutput();
        tick();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        cur = '{default: 0};
        drive(cur);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        stim_t s;
        int    k;

        // Out-of-order completion followed by a same-tag wb0/wb1 collision.
        tbl[0]  = '{mk_alloc(1),                1'b1, 4'd0, 1'b0, 4'd0, 32'h0,  0};
        tbl[1]  = '{mk_alloc(2),                1'b1, 4'd1, 1'b0, 4'd0, 32'h0,  1};
        tbl[2]  = '{mk_alloc(3),                1'b1, 4'd2, 1'b0, 4'd0, 32'h0,  2};
        tbl[3]  = '{mk_wb0(2, 32'hA),           1'b1, 4'd3, 1'b0, 4'd0, 32'h0,  3};
        tbl[4]  = '{mk_wb1(0, 32'hB),           1'b1, 4'd3, 1'b0, 4'd0, 32'h0,  3};
        tbl[5]  = '{mk_wb0(1, 32'hC),           1'b1, 4'd3, 1'b1, 4'd0, 32'hB,  3};
        tbl[6]  = '{idle(),                     1'b1, 4'd3, 1'b1, 4'd1, 32'hC,  2};
        tbl[7]  = '{idle(),                     1'b1, 4'd3, 1'b1, 4'd2, 32'hA,  1};
        tbl[8]  = '{mk_alloc(4),                1'b1, 4'd3, 1'b0, 4'd0, 32'h0,  0};
        tbl[9]  = '{mk_wb0(3, 32'h11),          1'b1, 4'd4, 1'b0, 4'd0, 32'h0,  1};
        tbl[10] = '{idle(),                     1'b1, 4'd4, 1'b1, 4'd3, 32'h11, 1};
        tbl[11] = '{idle(),                     1'b1, 4'd4, 1'b0, 4'd0, 32'h0,  0};
        tbl[9].s.w1v = 1'b1;
        tbl[9].s.w1t = 4'd3;
        tbl[9].s.w1d = 32'h22;

        cur = '{default: 0};
        drive(cur);
        model_reset();

        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].s);
            checkOutput();
            chk($sformatf("tbl%0d alloc_ready", i), 64'(alloc_ready), 64'(tbl[i].ar));
            chk($sformatf("tbl%0d alloc_tag", i), 64'(alloc_tag), 64'(tbl[i].tag));
            chk($sformatf("tbl%0d cmt_valid", i), 64'(cmt_valid), 64'(tbl[i].cv));
            if (tbl[i].cv) begin
                chk($sformatf("tbl%0d cmt_tag", i), 64'(cmt_tag), 64'(tbl[i].ct));
                chk($sformatf("tbl%0d cmt_data", i), 64'(cmt_data), 64'(tbl[i].cd));
            end
            chk($sformatf("tbl%0d count", i), 64'(count), 64'(tbl[i].cnt));
            tick();
        end

        // Fill to DEPTH, refuse one more, then free one slot and see the tag wrap to 0.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk_alloc(i));
            checkOutput();
            chk("fill alloc_tag", 64'(alloc_tag), 64'(i));
            tick();
        end
        applyStimulus(mk_alloc(20));
        checkOutput();
        chk("full count", 64'(count), 64'(DEPTH));
        chk("full alloc_ready", 64'(alloc_ready), 64'(0));
        tick();
        step(mk_wb0(0, 32'h55));
        applyStimulus(idle());
        checkOutput();
        chk("fill commit", 64'(cmt_valid), 64'(1));
        tick();
        applyStimulus(idle());
        checkOutput();
        chk("refill alloc_ready", 64'(alloc_ready), 64'(1));
        chk("refill alloc_tag", 64'(alloc_tag), 64'(0));
        tick();

        // Mispredict on tag 0 with completed younger entries behind it.
        doReset();
        for (int i = 0; i < 4; i++) step(mk_alloc(i + 1));
        for (int i = 1; i < 4; i++) step(mk_wb1(i, i));
        s = mk_wb0(0, 32'h99);
        s.w0k  = 1'b1;
        s.w0pc = 32'h1000;
        step(s);
        applyStimulus(idle());
        checkOutput();
        chk("mispredict cmt_valid", 64'(cmt_valid), 64'(1));
        chk("mispredict cmt_tag", 64'(cmt_tag), 64'(0));
        tick();
        applyStimulus(idle());
        checkOutput();
        chk("redirect_valid", 64'(redirect_valid), 64'(1));
        chk("redirect_pc", 64'(redirect_pc), 64'(32'h1000));
        chk("redirect count", 64'(count), 64'(0));
        tick();
        repeat (3) begin
            applyStimulus(idle());
            checkOutput();
            chk("redirect drop", 64'(redirect_valid), 64'(0));
            chk("flushed no commit", 64'(cmt_valid), 64'(0));
            tick();
        end

        // Store at the head waits for st_ack; ack under rdy=0 is ignored.
        doReset();
        s = mk_alloc(0);
        s.ast = 1'b1;
        step(s);
        step(mk_alloc(7));
        step(mk_wb0(1, 32'h77));
        repeat (5) begin
            applyStimulus(idle());
            checkOutput();
            chk("store st_valid", 64'(st_valid), 64'(1));
            chk("store st_tag", 64'(st_tag), 64'(0));
            chk("store count", 64'(count), 64'(2));
            chk("store cmt_valid", 64'(cmt_valid), 64'(0));
            tick();
        end
        s = idle();
        s.rdy = 1'b0;
        s.ack = 1'b1;
        applyStimulus(s);
        checkOutput();
        chk("stall st_valid", 64'(st_valid), 64'(0));
        chk("stall alloc_ready", 64'(alloc_ready), 64'(0));
        tick();
        s = idle();
        s.ack = 1'b1;
        applyStimulus(s);
        checkOutput();
        chk("ack st_valid", 64'(st_valid), 64'(1));
        chk("ack count", 64'(count), 64'(2));
        tick();
        applyStimulus(idle());
        checkOutput();
        chk("after store cmt_valid", 64'(cmt_valid), 64'(1));
        chk("after store cmt_tag", 64'(cmt_tag), 64'(1));
        chk("after store cmt_data", 64'(cmt_data), 64'(32'h77));
        tick();

        // External flush with eight entries in flight, allocation requested alongside.
        doReset();
        for (int i = 0; i < 8; i++) step(mk_alloc(i));
        s = mk_alloc(9);
        s.fl = 1'b1;
        applyStimulus(s);
        checkOutput();
        chk("flush alloc_ready", 64'(alloc_ready), 64'(0));
        tick();
        applyStimulus(idle());
        checkOutput();
        chk("flush count", 64'(count), 64'(0));
        tick();

        // Reset dropped mid-fill clears outputs without waiting for a clock.
        doReset();
        s = mk_alloc(0);
        s.ast = 1'b1;
        step(s);
        for (int i = 1; i < 5; i++) step(mk_alloc(i));
        applyStimulus(idle());
        chk("pre-reset st_valid", 64'(st_valid), 64'(1));
        rst = 1'b0;
        #1;
        chk("reset cmt_valid", 64'(cmt_valid), 64'(0));
        chk("reset st_valid", 64'(st_valid), 64'(0));
        chk("reset alloc_ready", 64'(alloc_ready), 64'(0));
        chk("reset alloc_tag", 64'(alloc_tag), 64'(0));
        chk("reset count", 64'(count), 64'(0));
        chk("reset redirect_valid", 64'(redirect_valid), 64'(0));

        // Randomised traffic against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            s       = idle();
            s.rdy   = ($urandom_range(9) != 0);
            s.av    = ($urandom_range(9) < 6);
            s.ast   = ($urandom_range(4) == 0);
            s.apred = 1'($urandom_range(1));
            s.ard   = REG_W'($urandom);
            if (rob_q.size() > 0 && $urandom_range(1) == 1) begin
                k      = int'($urandom_range(rob_q.size() - 1));
                s.w0v  = 1'b1;
                s.w0t  = TAG_W'(rob_q[k].tag);
                s.w0d  = $urandom;
                s.w0k  = ($urandom_range(19) == 0) ? !rob_q[k].pred : rob_q[k].pred;
                s.w0pc = $urandom;
            end else if ($urandom_range(9) == 0) begin
                s.w0v  = 1'b1;
                s.w0t  = TAG_W'($urandom);
                s.w0d  = $urandom;
                s.w0k  = 1'($urandom_range(1));
                s.w0pc = $urandom;
            end
            if (rob_q.size() > 0 && $urandom_range(2) != 0) begin
                s.w1v = 1'b1;
                s.w1t = ($urandom_range(4) == 0) ? s.w0t
                                                 : TAG_W'(rob_q[$urandom_range(rob_q.size() - 1)].tag);
                s.w1d = $urandom;
            end
            s.ack = ($urandom_range(9) < 4);
            s.fl  = s.rdy && ($urandom_range(99) == 0);
            step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
